cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Completion-bus scheduler for the R10K out-of-order core. Each cycle it selects up to N_CDB finished results from N_FU functional-unit requesters, grants them with rotating (round-robin) priority, and drives the registered CDB lanes. The ROB complete port, RS wakeup and register-file write port all consume these lanes. Ungranted requesters are back-pressured until a later grant.

## Interface
- N_FU, 4, number of functional-unit requesters
- N_CDB, 2, number of CDB lanes (equals N_WAY)
- TAG_BITS, 6, physical-register tag width (equals CDB_BITS); tag 0 is reserved and means "no destination"
- XLEN, 32, result data width

- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  squash; synchronous, active-high
- fu_req  in  N_FU  requester i holds a completed result
- fu_tag  in  N_FU x TAG_BITS  destination tag per requester
- fu_data  in  N_FU x XLEN  result data per requester
- fu_wr_en  in  N_FU  requester result writes the register file
- fu_grant  out  N_FU  combinational; result i is accepted this cycle
- cdb_valid  out  N_CDB  lane carries a result (registered)
- cdb_tag  out  N_CDB x TAG_BITS  broadcast tag (registered)
- cdb_data  out  N_CDB x XLEN  broadcast data (registered)
- cdb_wr_en  out  N_CDB  register-file write enable (registered)
- cdb_count  out  clog2(N_CDB)+1  number of valid lanes (registered)

## Operation
- Eligible requester: fu_req[i]=1 and fu_tag[i]!=0. A request with tag 0 is never granted and the FU must drop it.
- Priority pointer rr_ptr, clog2(N_FU) bits. Scan order is rr_ptr, rr_ptr+1, … mod N_FU.
- Grant rule: the first min(N_CDB, #eligible) eligible requesters in scan order receive fu_grant=1.
- Lane assignment: the k-th granted requester in scan order is assigned lane k. Lanes are packed from 0, with no gaps.
- Pointer update at clock edge when ≥1 grant: rr_ptr ← (index of the last granted requester + 1) mod N_FU.
- Pointer update with no grants: rr_ptr is unchanged.
- Handshake: an FU holds fu_req, fu_tag, fu_data and fu_wr_en stable until it sees fu_grant high in the same cycle. It may present a new result the following cycle.
- The arbiter never grants a requester whose fu_req is low.
- Flush cycle: fu_grant is all 0. At the next edge cdb_valid, cdb_wr_en and cdb_count are cleared, and rr_ptr is preserved. FUs are responsible for dropping squashed requests.
- Fairness: with all N_FU eligible every cycle, each requester is granted at least once every ceil(N_FU/N_CDB) cycles.

## Timing
- fu_grant is combinational from fu_req, fu_tag, rr_ptr and flush, with zero latency.
- Granted results appear on the CDB lanes exactly 1 cycle after grant.
- Lanes with no grant in the previous cycle have cdb_valid=0, cdb_wr_en=0 and tag/data driven to 0.
- Reset values: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_wr_en=0, cdb_count=0, rr_ptr=0. While reset is asserted, fu_grant=0.
- Reset or flush asserted together with requests: no grant is issued and nothing is latched.
- Throughput: N_CDB results per cycle sustained. There are no bubbles between consecutive grants to the same FU.
- Pointer wrap: the last granted index N_FU-1 sets rr_ptr to 0.

## Test plan
- Single request, N_FU=4, N_CDB=2: fu_req=0001, tag 5, data 0xDEAD -> fu_grant=0001 same cycle. Next cycle lane0 valid with tag 5 / data 0xDEAD, lane1 invalid, cdb_count=1, rr_ptr=1.
- Saturation: fu_req=1111 held for 4 cycles from rr_ptr=0 -> grants 0011, 1100, 0011, 1100. Lane order is {0,1}, {2,3}, … and rr_ptr cycles 2, 0, 2, 0.
- Wrap-around: rr_ptr=3, fu_req=1011 -> fu_grant=1001 with lane0=FU3 and lane1=FU0; rr_ptr becomes 1.
- Tag-0 filter: fu_req=0011 with fu_tag[0]=0 and fu_tag[1]=9 -> fu_grant=0010, lane0 tag 9, cdb_count=1.
- Flush: fu_req=1111 with flush=1 -> fu_grant=0000. Next cycle cdb_valid=00 and cdb_count=0, and rr_ptr is unchanged.
- Reset mid-stream: reset during saturated traffic -> the next cycle shows all outputs 0 and rr_ptr=0. After release with fu_req=1111, the first grant is 0011.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: picks up to N_CDB finished FU results per cycle in
// rotating-priority order and drives them on registered CDB lanes.
module cdb_arbiter #(
    parameter int unsigned N_FU     = 4,
    parameter int unsigned N_CDB    = 2,
    parameter int unsigned TAG_BITS = 6,
    parameter int unsigned XLEN     = 32
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     flush,
    input  logic [N_FU-1:0]                          fu_req,
    input  logic [N_FU-1:0][TAG_BITS-1:0]            fu_tag,
    input  logic [N_FU-1:0][XLEN-1:0]                fu_data,
    input  logic [N_FU-1:0]                          fu_wr_en,
    output logic [N_FU-1:0]                          fu_grant,
    output logic [N_CDB-1:0]                         cdb_valid,
    output logic [N_CDB-1:0][TAG_BITS-1:0]           cdb_tag,
    output logic [N_CDB-1:0][XLEN-1:0]               cdb_data,
    output logic [N_CDB-1:0]                         cdb_wr_en,
    output logic [$clog2(N_CDB):0]                   cdb_count
);

    localparam int unsigned PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int unsigned CNT_W = $clog2(N_CDB) + 1;

    // Priority pointer and registered lane state
    logic [PTR_W-1:0]                r_rr_ptr;
    logic [N_CDB-1:0]                r_cdb_valid;
    logic [N_CDB-1:0][TAG_BITS-1:0]  r_cdb_tag;
    logic [N_CDB-1:0][XLEN-1:0]      r_cdb_data;
    logic [N_CDB-1:0]                r_cdb_wr_en;
    logic [CNT_W-1:0]                r_cdb_count;

    // Arbitration results for the current cycle
    logic [N_FU-1:0]                 w_grant;
    logic [CNT_W-1:0]                w_cnt;
    logic [PTR_W-1:0]                w_idx;
    logic [PTR_W-1:0]                w_last;
    logic [PTR_W-1:0]                w_rr_next;
    logic [N_CDB-1:0]                w_lane_vld;
    logic [N_CDB-1:0][PTR_W-1:0]     w_lane_src;
    logic [N_CDB-1:0][TAG_BITS-1:0]  w_lane_tag;
    logic [N_CDB-1:0][XLEN-1:0]      w_lane_data;
    logic [N_CDB-1:0]                w_lane_wr;

    // Scan requesters from rr_ptr, granting the first N_CDB eligible ones and packing lanes from 0
    always_comb begin
        w_grant    = '0;
        w_cnt      = '0;
        w_idx      = '0;
        w_last     = r_rr_ptr;
        w_lane_vld = '0;
        w_lane_src = '0;
        if (!reset && !flush) begin
            for (int off = 0; off < int'(N_FU); off++) begin
                w_idx = PTR_W'((32'(r_rr_ptr) + 32'(off)) % N_FU);
                // Tag 0 means "no destination"; such results are never broadcast
                if (fu_req[w_idx] && (fu_tag[w_idx] != '0) && (32'(w_cnt) < N_CDB)) begin
                    w_grant[w_idx] = 1'b1;
                    for (int l = 0; l < int'(N_CDB); l++) begin
                        if (w_cnt == CNT_W'(l)) begin
                            w_lane_vld[l] = 1'b1;
                            w_lane_src[l] = w_idx;
                        end
                    end
                    w_cnt  = w_cnt + CNT_W'(1);
                    w_last = w_idx;
                end
            end
        end
    end

    // Advance priority past the last granted requester; hold when nothing granted
    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_cnt != '0) begin
            w_rr_next = PTR_W'((32'(w_last) + 32'd1) % N_FU);
        end
    end

    // Steer granted results onto their lanes; idle lanes carry zeros
    always_comb begin
        w_lane_tag  = '0;
        w_lane_data = '0;
        w_lane_wr   = '0;
        for (int l = 0; l < int'(N_CDB); l++) begin
            if (w_lane_vld[l]) begin
                w_lane_tag[l]  = fu_tag[w_lane_src[l]];
                w_lane_data[l] = fu_data[w_lane_src[l]];
                w_lane_wr[l]   = fu_wr_en[w_lane_src[l]];
            end
        end
    end

    // Register lanes and pointer; flush needs no special case since it suppresses all grants
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_wr_en <= '0;
            r_cdb_count <= '0;
        end else begin
            r_rr_ptr    <= w_rr_next;
            r_cdb_valid <= w_lane_vld;
            r_cdb_tag   <= w_lane_tag;
            r_cdb_data  <= w_lane_data;
            r_cdb_wr_en <= w_lane_wr;
            r_cdb_count <= w_cnt;
        end
    end

    assign fu_grant  = w_grant;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_wr_en = r_cdb_wr_en;
    assign cdb_count = r_cdb_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter (N_FU=4, N_CDB=2).
module tb_cdb_arbiter;

    logic                  clock;
    logic                  reset;
    logic                  flush;
    logic [3:0]            fu_req;
    logic [3:0][5:0]       fu_tag;
    logic [3:0][31:0]      fu_data;
    logic [3:0]            fu_wr_en;
    logic [3:0]            fu_grant;
    logic [1:0]            cdb_valid;
    logic [1:0][5:0]       cdb_tag;
    logic [1:0][31:0]      cdb_data;
    logic [1:0]            cdb_wr_en;
    logic [1:0]            cdb_count;

    cdb_arbiter #(.N_FU(4), .N_CDB(2), .TAG_BITS(6), .XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .fu_req    (fu_req),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_wr_en  (fu_wr_en),
        .fu_grant  (fu_grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_wr_en (cdb_wr_en),
        .cdb_count (cdb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic            rst;
        logic            fl;
        logic [3:0]      req;
        logic [3:0][5:0] tag;
        logic [3:0][31:0] data;
        logic [3:0]      wr;
        logic [3:0]      exp_grant;
        logic [1:0]      exp_cnt;
        logic [1:0]      exp_vld;
        logic [1:0][5:0] exp_tag;
        logic [1:0][31:0] exp_data;
        logic [1:0]      exp_wr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Default requester payload: tag 8+i, data A000_000i, FU0/FU2 write the RF
    function automatic vec_t base(input logic rst, input logic fl, input logic [3:0] req,
                                  input logic [3:0] grant, input logic [1:0] cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.req = req; v.wr = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            v.tag[i]  = 6'(8 + i);
            v.data[i] = 32'hA000_0000 + 32'(i);
        end
        v.exp_grant = grant;
        v.exp_cnt   = cnt;
        v.exp_vld   = '0;
        v.exp_tag   = '0;
        v.exp_data  = '0;
        v.exp_wr    = '0;
        return v;
    endfunction

    // Fill expected lanes from the hand-chosen source FU of each lane (-1 = idle)
    function automatic vec_t lanes(input vec_t vi, input int l0, input int l1);
        vec_t v;
        int src[2];
        v = vi;
        src[0] = l0; src[1] = l1;
        for (int k = 0; k < 2; k++) begin
            if (src[k] >= 0) begin
                v.exp_vld[k]  = 1'b1;
                v.exp_tag[k]  = v.tag[src[k]];
                v.exp_data[k] = v.data[src[k]];
                v.exp_wr[k]   = v.wr[src[k]];
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset    = v.rst;
        flush    = v.fl;
        fu_req   = v.req;
        fu_tag   = v.tag;
        fu_data  = v.data;
        fu_wr_en = v.wr;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; fu_req = '0; fu_tag = '0; fu_data = '0; fu_wr_en = '0;
    endtask

    vec_t v;
    int   age[4];

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", 64'(cdb_valid), 64'(0));
        chk("reset_count", 64'(cdb_count), 64'(0));
        chk("reset_tag",   64'(cdb_tag),   64'(0));
        chk("reset_grant", 64'(fu_grant),  64'(0));

        // ptr=0 after reset
        vecs.push_back(lanes(base(1, 0, 4'b1111, 4'b0000, 2'd0), -1, -1));
        v = base(0, 0, 4'b0001, 4'b0001, 2'd1);
        v.tag[0] = 6'd5; v.data[0] = 32'h0000_DEAD;
        vecs.push_back(lanes(v, 0, -1));                                     // ptr -> 1
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0110, 2'd2), 1, 2));    // ptr -> 3
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b1001, 2'd2), 3, 0));    // ptr -> 1
        vecs.push_back(lanes(base(0, 0, 4'b0100, 4'b0100, 2'd1), 2, -1));   // ptr -> 3
        vecs.push_back(lanes(base(0, 0, 4'b1000, 4'b1000, 2'd1), 3, -1));   // ptr -> 0 (wrap)
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0011, 2'd2), 0, 1));    // saturation
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b1100, 2'd2), 2, 3));
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0011, 2'd2), 0, 1));
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b1100, 2'd2), 2, 3));    // ptr -> 0
        vecs.push_back(lanes(base(0, 0, 4'b0100, 4'b0100, 2'd1), 2, -1));   // ptr -> 3
        vecs.push_back(lanes(base(0, 0, 4'b1011, 4'b1001, 2'd2), 3, 0));    // wrap, ptr -> 1
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0110, 2'd2), 1, 2));    // ptr -> 3
        v = base(0, 0, 4'b0011, 4'b0010, 2'd1);
        v.tag[0] = 6'd0; v.tag[1] = 6'd9;
        vecs.push_back(lanes(v, 1, -1));                                     // tag-0 filter, ptr -> 2
        vecs.push_back(lanes(base(0, 1, 4'b1111, 4'b0000, 2'd0), -1, -1));  // flush, ptr stays 2
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b1100, 2'd2), 2, 3));    // ptr -> 0
        vecs.push_back(lanes(base(0, 0, 4'b0000, 4'b0000, 2'd0), -1, -1));  // idle, ptr stays 0
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0011, 2'd2), 0, 1));    // ptr -> 2
        vecs.push_back(lanes(base(1, 0, 4'b1111, 4'b0000, 2'd0), -1, -1));  // reset mid-stream
        vecs.push_back(lanes(base(0, 0, 4'b1111, 4'b0011, 2'd2), 0, 1));    // ptr -> 2

        foreach (vecs[n]) begin
            @(negedge clock);
            drive(vecs[n]);
            #1;
            chk($sformatf("v%0d_grant", n), 64'(fu_grant), 64'(vecs[n].exp_grant));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_valid", n), 64'(cdb_valid), 64'(vecs[n].exp_vld));
            chk($sformatf("v%0d_count", n), 64'(cdb_count), 64'(vecs[n].exp_cnt));
            chk($sformatf("v%0d_tag",   n), 64'(cdb_tag),   64'(vecs[n].exp_tag));
            chk($sformatf("v%0d_data0", n), 64'(cdb_data[0]), 64'(vecs[n].exp_data[0]));
            chk($sformatf("v%0d_data1", n), 64'(cdb_data[1]), 64'(vecs[n].exp_data[1]));
            chk($sformatf("v%0d_wr",    n), 64'(cdb_wr_en), 64'(vecs[n].exp_wr));
        end

        // Fairness under continuous full load: nobody waits more than 2 cycles
        for (int i = 0; i < 4; i++) age[i] = 0;
        v = base(0, 0, 4'b1111, 4'b0000, 2'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            drive(v);
            #1;
            chk($sformatf("fair%0d_popcount", c), 64'($countones(fu_grant)), 64'(2));
            for (int i = 0; i < 4; i++) begin
                age[i] = fu_grant[i] ? 0 : age[i] + 1;
                chk($sformatf("fair%0d_age_fu%0d", c, i), 64'(age[i] < 2), 64'(1));
            end
            @(posedge clock);
            #1;
            chk($sformatf("fair%0d_lanes", c), 64'(cdb_valid), 64'(2'b11));
        end

        // Flush then release: lanes clear, then a lone request resumes normally
        @(negedge clock);
        drive(base(0, 1, 4'b0001, 4'b0000, 2'd0));
        @(posedge clock);
        #1;
        chk("flush_count", 64'(cdb_count), 64'(0));
        @(negedge clock);
        drive(base(0, 0, 4'b0001, 4'b0000, 2'd0));
        #1;
        chk("post_flush_grant", 64'(fu_grant), 64'(4'b0001));
        @(posedge clock);
        #1;
        chk("post_flush_tag0", 64'(cdb_tag[0]), 64'(8));
        @(negedge clock);
        idle_inputs();
        @(posedge clock);
        #1;
        chk("idle_valid", 64'(cdb_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
